sccb_bus_arbiter: RTL and testbench

- Shares the single SCCB master among NUM_REQ requesters on the 1 MHz SCCB clock domain: OV5640 power-up config table, runtime AF/flash control, and register readback.
- Round-robin grant; one transaction in flight at a time.
- Presents the master's en/data/done handshake downstream and returns done, error and read data to the owning requester.
- A watchdog aborts transactions whose sccb_done never arrives, so a hung bus cannot stall the other requesters.

---
 rtl/sccb_bus_arbiter_pkg.sv | 24 ++
 rtl/sccb_bus_arbiter_if.sv | 36 +++
 rtl/sccb_bus_arbiter_rr_pick.sv | 35 +++
 rtl/sccb_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_sccb_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sccb_bus_arbiter_pkg.sv
// Shared SCCB definitions for the bus arbiter slice.
//   - transaction word / read byte widths
//   - arbiter FSM state encoding
//   - default requester count and watchdog length
//   - idx_w(): index width helper that never returns 0
package sccb_bus_arbiter_pkg;

    localparam int SCCB_DATA_W      = 24;   // {16-bit reg addr, 8-bit wr data}
    localparam int SCCB_RD_W        = 8;
    localparam int SCCB_NUM_REQ     = 3;
    localparam int SCCB_TIMEOUT_CYC = 2000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sccb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sccb_bus_arbiter_if.sv
// Requester-side and SCCB-master-side signals of the arbiter.
//   slave  : the arbiter view (takes requests, drives acks and the master)
//   master : the environment view (requesters + SCCB master)
// req_data is packed so requester i sits at bits [i*DATA_W +: DATA_W].
interface sccb_bus_arbiter_if
    import sccb_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = SCCB_NUM_REQ,
    parameter int DATA_W  = SCCB_DATA_W
) ();

    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             req_rd;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             ack;
    logic                           ack_err;
    logic [SCCB_RD_W-1:0]           ack_rd_data;
    logic [NUM_REQ-1:0]             gnt;
    logic                           busy;
    logic                           sccb_en;
    logic                           sccb_rd;
    logic [DATA_W-1:0]              sccb_data;
    logic                           sccb_done;
    logic [SCCB_RD_W-1:0]           sccb_rd_data;

    modport slave (
        input  req, req_rd, req_data, sccb_done, sccb_rd_data,
        output ack, ack_err, ack_rd_data, gnt, busy, sccb_en, sccb_rd, sccb_data
    );

    modport master (
        output req, req_rd, req_data, sccb_done, sccb_rd_data,
        input  ack, ack_err, ack_rd_data, gnt, busy, sccb_en, sccb_rd, sccb_data
    );

endinterface

// File: rtl/sccb_bus_arbiter_rr_pick.sv
// sccb_rr_pick: combinational round-robin selector.
//   req      : request vector
//   last_gnt : index of the previous owner; search starts at last_gnt+1
//   found    : at least one request is set
//   idx      : winning index (0 when !found)
//   onehot   : winning one-hot (0 when !found)
module sccb_rr_pick
    import sccb_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = SCCB_NUM_REQ,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic               found,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    // Offset k = NUM_REQ wraps back to last_gnt itself, so a lone
    // requester is re-granted every time.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[IDX_W'((int'(last_gnt) + k) % NUM_REQ)]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
            end
        end
        if (found) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/sccb_bus_arbiter.sv
// sccb_bus_arbiter: shares one SCCB master among NUM_REQ requesters.
//   clk, rst_n : 1 MHz clock, async active-low reset
//   bus        : sccb_bus_arbiter_if.slave (req/ack side and SCCB master side)
// Round-robin grant, one transaction in flight. IDLE -> ISSUE (sccb_en pulse)
// -> WAIT (for sccb_done or watchdog) -> RESP (ack pulse) -> IDLE.
// All outputs are registered. NUM_REQ legal 2..8, TIMEOUT_CYC >= 2.
module sccb_bus_arbiter
    import sccb_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = SCCB_NUM_REQ,
    parameter int DATA_W      = SCCB_DATA_W,
    parameter int TIMEOUT_CYC = SCCB_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    sccb_bus_arbiter_if.slave bus
);

    localparam int               IDX_W    = idx_w(NUM_REQ);
    localparam int               CNT_W    = idx_w(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    sccb_state_e          state;
    logic [IDX_W-1:0]     last_gnt;
    logic [IDX_W-1:0]     owner;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 timeout;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   pick_oh;

    logic [NUM_REQ-1:0]   ack_q;
    logic                 ack_err_q;
    logic [SCCB_RD_W-1:0] ack_rd_data_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 busy_q;
    logic                 sccb_en_q;
    logic                 sccb_rd_q;
    logic [DATA_W-1:0]    sccb_data_q;

    sccb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (bus.req),
        .last_gnt (last_gnt),
        .found    (pick_found),
        .idx      (pick_idx),
        .onehot   (pick_oh)
    );

    // Saturating watchdog. Abort fires on the edge where the counter would
    // step onto TIMEOUT_CYC-1, putting RESP exactly TIMEOUT_CYC cycles
    // after ISSUE.
    assign cnt_nxt = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);
    assign timeout = (cnt_nxt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            last_gnt      <= LAST_RST;
            owner         <= '0;
            cnt           <= '0;
            ack_q         <= '0;
            ack_err_q     <= 1'b0;
            ack_rd_data_q <= '0;
            gnt_q         <= '0;
            busy_q        <= 1'b0;
            sccb_en_q     <= 1'b0;
            sccb_rd_q     <= 1'b0;
            sccb_data_q   <= '0;
        end else begin
            // single-cycle pulses
            sccb_en_q <= 1'b0;
            ack_q     <= '0;
            ack_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Requester inputs are sampled only here; later changes
                    // to req/req_rd/req_data do not affect this transaction.
                    if (pick_found) begin
                        owner       <= pick_idx;
                        gnt_q       <= pick_oh;
                        busy_q      <= 1'b1;
                        sccb_rd_q   <= bus.req_rd[pick_idx];
                        sccb_data_q <= bus.req_data[pick_idx];
                        sccb_en_q   <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // sccb_done here is a leftover and is ignored
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // ack/err/data are loaded on entry so they are live
                    // during RESP; done wins over a same-cycle abort.
                    if (bus.sccb_done) begin
                        ack_q <= gnt_q;
                        if (sccb_rd_q) ack_rd_data_q <= bus.sccb_rd_data;
                        state <= ST_RESP;
                    end else if (timeout) begin
                        ack_q     <= gnt_q;
                        ack_err_q <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                ST_RESP: begin
                    last_gnt <= owner;
                    gnt_q    <= '0;
                    busy_q   <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack         = ack_q;
    assign bus.ack_err     = ack_err_q;
    assign bus.ack_rd_data = ack_rd_data_q;
    assign bus.gnt         = gnt_q;
    assign bus.busy        = busy_q;
    assign bus.sccb_en     = sccb_en_q;
    assign bus.sccb_rd     = sccb_rd_q;
    assign bus.sccb_data   = sccb_data_q;

endmodule

// File: tb/tb_sccb_bus_arbiter.sv
// Bench for sccb_bus_arbiter: table of transactions on a default-timeout
// instance with an ack scoreboard, plus hand-written timeout / done-vs-abort
// sequences on a TIMEOUT_CYC=10 instance and a reset-mid-WAIT sequence.
module tb_sccb_bus_arbiter;
    import sccb_bus_arbiter_pkg::*;

    typedef struct {
        logic [2:0]       req;
        logic [2:0]       rd;
        logic [2:0][23:0] w;
        int               dly;    // cycles from sccb_en to sccb_done
        logic [7:0]       rbyte;  // byte the master returns with done
        bit               drop;   // drop req right after ISSUE
        int               owner;  // expected winner
    } vec_t;

    typedef struct {
        logic [2:0] ack;
        logic       err;
        logic [7:0] rd;
        int         due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sccb_bus_arbiter_if #(.NUM_REQ(3), .DATA_W(24)) m ();
    sccb_bus_arbiter_if #(.NUM_REQ(3), .DATA_W(24)) t ();

    sccb_bus_arbiter #(.NUM_REQ(3), .DATA_W(24), .TIMEOUT_CYC(2000)) dut (
        .clk(clk), .rst_n(rst_n), .bus(m)
    );
    sccb_bus_arbiter #(.NUM_REQ(3), .DATA_W(24), .TIMEOUT_CYC(10)) dut_to (
        .clk(clk), .rst_n(rst_n), .bus(t)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_en_m(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (m.sccb_en) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL en_wait_main: got no sccb_en want pulse within 20 cycles");
        end
    endtask

    task automatic wait_en_t(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (t.sccb_en) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL en_wait_to: got no sccb_en want pulse within 20 cycles");
        end
    endtask

    function automatic vec_t mk(input logic [2:0] req, input logic [2:0] rd,
                                input logic [23:0] w2, input logic [23:0] w1,
                                input logic [23:0] w0, input int dly,
                                input logic [7:0] rbyte, input bit drop, input int owner);
        vec_t v;
        v.req = req; v.rd = rd; v.w = {w2, w1, w0}; v.dly = dly;
        v.rbyte = rbyte; v.drop = drop; v.owner = owner;
        return v;
    endfunction

    // Scoreboard: every ack pulse on the main instance must match the
    // oldest pushed expectation, including the cycle it shows up in.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && m.ack != 3'b000) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ack: got %b want none", m.ack);
            end else begin
                e = sb.pop_front();
                chk("ack_onehot", 32'(m.ack), 32'(e.ack));
                chk("ack_err", 32'(m.ack_err), 32'(e.err));
                chk("ack_rd_data", 32'(m.ack_rd_data), 32'(e.rd));
                chk("ack_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish before 100us");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        vec_t       v;
        bit         ok;
        bit         got;
        logic [7:0] hold;
        logic [2:0] oh;
        int         ce;

        //             req     rd      w2        w1        w0      dly rbyte  drop own
        vecs[0]  = mk(3'b001, 3'b000, 24'h0,    24'h0,    24'h300858, 50, 8'h00, 0, 0);
        vecs[1]  = mk(3'b010, 3'b000, 24'h0,    24'h302203, 24'h0,   3, 8'hEE, 1, 1);
        vecs[2]  = mk(3'b100, 3'b100, 24'h300A00, 24'h0,  24'h0,     7, 8'h56, 0, 2);
        vecs[3]  = mk(3'b111, 3'b010, 24'h301702, 24'h300B00, 24'h300858, 1, 8'h11, 0, 0);
        vecs[4]  = mk(3'b111, 3'b010, 24'h301702, 24'h300B00, 24'h300858, 2, 8'h22, 0, 1);
        vecs[5]  = mk(3'b111, 3'b010, 24'h301702, 24'h300B00, 24'h300858, 5, 8'h33, 0, 2);
        vecs[6]  = mk(3'b111, 3'b010, 24'h301702, 24'h300B00, 24'h300858, 1, 8'h44, 0, 0);
        vecs[7]  = mk(3'b111, 3'b010, 24'h301702, 24'h300B00, 24'h300858, 3, 8'h55, 0, 1);
        vecs[8]  = mk(3'b111, 3'b010, 24'h301702, 24'h300B00, 24'h300858, 2, 8'h66, 0, 2);
        vecs[9]  = mk(3'b010, 3'b000, 24'h0,    24'h302203, 24'h0,   2, 8'h77, 0, 1);
        vecs[10] = mk(3'b010, 3'b000, 24'h0,    24'h302204, 24'h0,   1, 8'h78, 0, 1);
        vecs[11] = mk(3'b101, 3'b001, 24'h300858, 24'h0,  24'h300A00, 2, 8'h88, 0, 2);
        vecs[12] = mk(3'b101, 3'b001, 24'h300858, 24'h0,  24'h300A00, 4, 8'h99, 0, 0);

        m.req = '0; m.req_rd = '0; m.req_data = '0; m.sccb_done = 1'b0; m.sccb_rd_data = 8'hA5;
        t.req = '0; t.req_rd = '0; t.req_data = '0; t.sccb_done = 1'b0; t.sccb_rd_data = 8'hA5;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(m.ack), 0);
        chk("rst_ack_err", 32'(m.ack_err), 0);
        chk("rst_ack_rd_data", 32'(m.ack_rd_data), 0);
        chk("rst_gnt", 32'(m.gnt), 0);
        chk("rst_busy", 32'(m.busy), 0);
        chk("rst_sccb_en", 32'(m.sccb_en), 0);
        chk("rst_sccb_rd", 32'(m.sccb_rd), 0);
        chk("rst_sccb_data", 32'(m.sccb_data), 0);
        chk("rst_to_busy", 32'(t.busy), 0);
        rst_n = 1'b1;

        // table-driven transactions on the main instance
        hold = 8'h00;
        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            m.req = v.req; m.req_rd = v.rd; m.req_data = v.w;
            wait_en_m(ok);
            if (ok) begin
                oh = '0; oh[v.owner] = 1'b1;
                chk("gnt", 32'(m.gnt), 32'(oh));
                chk("sccb_data", 32'(m.sccb_data), 32'(v.w[v.owner]));
                chk("sccb_rd", 32'(m.sccb_rd), 32'(v.rd[v.owner]));
                chk("busy", 32'(m.busy), 1);
                chk("rd_data_held", 32'(m.ack_rd_data), 32'(hold));
                if (v.drop) m.req = '0;
                @(negedge clk);
                chk("en_one_pulse", 32'(m.sccb_en), 0);
                repeat (v.dly - 1) @(negedge clk);
                if (v.rd[v.owner]) hold = v.rbyte;
                sb.push_back('{ack: oh, err: 1'b0, rd: hold, due: cyc + 1});
                m.sccb_done = 1'b1; m.sccb_rd_data = v.rbyte;
                @(negedge clk);
                m.sccb_done = 1'b0; m.sccb_rd_data = 8'hA5;
            end
        end
        m.req = '0;
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("idle_gnt", 32'(m.gnt), 0);
        chk("idle_busy", 32'(m.busy), 0);

        // stray done in IDLE
        m.sccb_done = 1'b1;
        @(negedge clk);
        m.sccb_done = 1'b0;
        chk("stray_idle_busy", 32'(m.busy), 0);
        chk("stray_idle_en", 32'(m.sccb_en), 0);

        // timeout instance: read to seed ack_rd_data
        t.req = 3'b001; t.req_rd = 3'b001; t.req_data[0] = 24'h300A00;
        wait_en_t(ok);
        if (ok) begin
            chk("to_seed_gnt", 32'(t.gnt), 32'b001);
            t.req = '0;
            @(negedge clk);
            @(negedge clk); t.sccb_done = 1'b1; t.sccb_rd_data = 8'h77;
            @(negedge clk); t.sccb_done = 1'b0; t.sccb_rd_data = 8'hA5;
            chk("to_seed_ack", 32'(t.ack), 32'b001);
            chk("to_seed_rd", 32'(t.ack_rd_data), 32'h77);
        end

        // abort: requester 1 read, done never comes; requester 2 waiting
        t.req = 3'b110; t.req_rd = 3'b010;
        t.req_data[1] = 24'h302900; t.req_data[2] = 24'h300A00;
        wait_en_t(ok);
        ce = cyc;
        chk("to_gnt", 32'(t.gnt), 32'b010);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (t.ack != 3'b000) got = 1'b1;
        end
        chk("to_ack_seen", 32'(got), 1);
        chk("to_ack", 32'(t.ack), 32'b010);
        chk("to_ack_err", 32'(t.ack_err), 1);
        chk("to_rd_unchanged", 32'(t.ack_rd_data), 32'h77);
        chk("to_latency", cyc - ce, 10);

        // next requester granted; done lands on the abort cycle
        t.req = 3'b100; t.req_rd = 3'b100;
        wait_en_t(ok);
        ce = cyc;
        chk("to_next_gnt", 32'(t.gnt), 32'b100);
        repeat (9) @(negedge clk);
        t.sccb_done = 1'b1; t.sccb_rd_data = 8'h5A;
        @(negedge clk);
        t.sccb_done = 1'b0; t.sccb_rd_data = 8'hA5;
        t.req = '0;
        chk("race_ack", 32'(t.ack), 32'b100);
        chk("race_err", 32'(t.ack_err), 0);
        chk("race_rd", 32'(t.ack_rd_data), 32'h5A);
        chk("race_latency", cyc - ce, 10);

        // stray done in ISSUE, then async reset in WAIT
        m.req = 3'b010; m.req_rd = 3'b000; m.req_data[1] = 24'h302203;
        wait_en_m(ok);
        m.sccb_done = 1'b1;
        @(negedge clk);
        m.sccb_done = 1'b0;
        chk("stray_issue_busy", 32'(m.busy), 1);
        chk("stray_issue_ack", 32'(m.ack), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(m.ack), 0);
        chk("mid_rst_gnt", 32'(m.gnt), 0);
        chk("mid_rst_busy", 32'(m.busy), 0);
        chk("mid_rst_en", 32'(m.sccb_en), 0);
        chk("mid_rst_sccb_data", 32'(m.sccb_data), 0);
        chk("mid_rst_rd_data", 32'(m.ack_rd_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m.req = 3'b111; m.req_rd = 3'b000;
        m.req_data = {24'h301702, 24'h300B00, 24'h300858};
        wait_en_m(ok);
        chk("post_rst_gnt", 32'(m.gnt), 32'b001);
        @(negedge clk);
        sb.push_back('{ack: 3'b001, err: 1'b0, rd: 8'h00, due: cyc + 1});
        m.sccb_done = 1'b1; m.sccb_rd_data = 8'hC3;
        @(negedge clk);
        m.sccb_done = 1'b0; m.sccb_rd_data = 8'hA5;
        m.req = '0;
        repeat (2) @(negedge clk);
        chk("sb_final", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
